// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// State encodings, latency counter width, word/byte geometry.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W  = 4;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int NBYTES = WORD_W / BYTE_W;

endpackage

// File: rtl/mem_resp_array.sv
// Word storage with byte-enabled synchronous write and registered read.
// Reset clears every word and the read register.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc,
  input  logic              we,
  input  logic              ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [NBYTES-1:0] wstrb,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we)
        for (int b = 0; b < NBYTES; b++)
          if (wstrb[b])
            mem[addr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
      // Stores and rejected accesses return zero data
      if (acc)
        rdata <= ld ? mem[addr] : '0;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency load/store responder for the core data port.
// One transaction in flight; misaligned/out-of-range accesses flagged.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [NBYTES-1:0] req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic rdy_q;
  logic vld_q;
  logic err_q;
  logic do_acc;

  logic              wr_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [NBYTES-1:0] wstrb_q;

  logic              acc_wr;
  logic [31:0]       acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [NBYTES-1:0] acc_wstrb;
  logic              acc_err;
  logic              idle;

  assign idle = (state == IDLE);

  // Zero-latency accesses use the live request, others the captured one
  assign acc_wr    = idle ? req_write : wr_q;
  assign acc_addr  = idle ? req_addr  : addr_q;
  assign acc_wdata = idle ? req_wdata : wdata_q;
  assign acc_wstrb = idle ? req_wstrb : wstrb_q;

  assign acc_err = (acc_addr[1:0] != 2'b00)
                 || (acc_addr[31:ADDR_W+2] != '0);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    do_acc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && rdy_q) begin
          cnt_nx = CNT_W'(LATENCY);
          if (LATENCY == 0) begin
            do_acc   = 1'b1;
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          do_acc   = 1'b1;
          cnt_nx   = '0;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      rdy_q <= (state_nx == IDLE);
      vld_q <= (state_nx == RESP);
      if (do_acc)
        err_q <= acc_err;
      if (idle && req_valid && rdy_q) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
    end
  end

  mem_resp_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .acc   (do_acc),
    .we    (do_acc && acc_wr && !acc_err),
    .ld    (do_acc && !acc_wr && !acc_err),
    .addr  (acc_addr[ADDR_W+1:2]),
    .wdata (acc_wdata),
    .wstrb (acc_wstrb),
    .rdata (resp_rdata)
  );

  assign req_ready  = rdy_q;
  assign resp_valid = vld_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 2, 0, 4) checked
// against a word-array model with directed and random traffic.
module tb_mem_responder;

  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [3:0]  req_wstrb  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  logic [31:0] mem [3][DEPTH];
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .ADDR_W  (AW),
      .LATENCY (g == 0 ? 2 : (g == 1 ? 0 : 4))
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_wstrb  (req_wstrb[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  function automatic int lat_of(input int d);
    return d == 0 ? 2 : (d == 1 ? 0 : 4);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < DEPTH; i++)
        mem[d][i] = '0;
  endtask

  task automatic model(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws,
                       output logic [31:0] rd, output logic er);
    int idx;
    er = (a % 4 != 0) || (a / 4 >= DEPTH);
    rd = '0;
    if (!er) begin
      idx = int'(a / 4);
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (ws[b]) mem[d][idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        rd = mem[d][idx];
      end
    end
  endtask

  task automatic do_txn(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input int hold, output logic [31:0] got,
                        output int acc_cyc);
    logic [31:0] erd;
    logic eer;
    int waited = 0;
    int c = 0;
    while (!req_ready[d] && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    check1("ready_wait", waited < 20, 1'b1);
    req_valid[d] = 1'b1;
    req_write[d] = w;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_wstrb[d] = ws;
    resp_ready[d] = 1'b0;
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid[d] = 1'b0;
    req_write[d] = 1'($urandom);
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    req_wstrb[d] = 4'($urandom);
    model(d, w, a, wd, ws, erd, eer);
    while (!resp_valid[d] && c < 40) begin
      @(posedge clk); #1; c++;
    end
    // first edge that samples resp_valid high, counted from acceptance
    check("latency", 32'(c + 1), 32'(lat_of(d) + 1));
    check1("busy_ready", req_ready[d], 1'b0);
    check("rdata", resp_rdata[d], erd);
    check1("err", resp_err[d], eer);
    got = resp_rdata[d];
    if (hold > 0) begin
      req_valid[d] = 1'b1;
      req_write[d] = 1'b1;
      req_addr[d]  = 32'($urandom_range(0, DEPTH - 1)) << 2;
      req_wstrb[d] = 4'hF;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        check1("hold_valid", resp_valid[d], 1'b1);
        check("hold_rdata", resp_rdata[d], erd);
        check1("hold_err", resp_err[d], eer);
        check1("hold_ready", req_ready[d], 1'b0);
      end
      req_valid[d] = 1'b0;
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    check1("idle_valid", resp_valid[d], 1'b0);
    check1("idle_ready", req_ready[d], 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    logic [31:0] wd;
    int a1, a2, kind;

    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 0; req_write[d] = 0; req_addr[d] = 0;
      req_wdata[d] = 0; req_wstrb[d] = 0; resp_ready[d] = 0;
    end
    clear_model();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      check1("rst_req_ready", req_ready[d], 1'b0);
      check1("rst_resp_valid", resp_valid[d], 1'b0);
      check("rst_rdata", resp_rdata[d], 32'h0);
      check1("rst_err", resp_err[d], 1'b0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++)
      check1("post_rst_ready", req_ready[d], 1'b1);

    // LATENCY=2 directed traffic
    do_txn(0, 1, 32'h8, 32'hDEADBEEF, 4'hF, 0, got, a1);
    check("store_rdata", got, 32'h0);
    do_txn(0, 0, 32'h8, 32'h0, 4'h0, 0, got, a1);
    check("load_8", got, 32'hDEADBEEF);
    do_txn(0, 1, 32'h8, 32'h00001200, 4'h2, 0, got, a1);
    do_txn(0, 0, 32'h8, 32'h0, 4'hF, 0, got, a1);
    check("byte_merge", got, 32'hDEAD12EF);
    do_txn(0, 0, 32'h6, 32'h0, 4'h0, 0, got, a1);
    do_txn(0, 1, 32'h80, 32'hFFFFFFFF, 4'hF, 0, got, a1);
    do_txn(0, 0, 32'h0, 32'h0, 4'h0, 0, got, a1);
    check("word0_kept", got, 32'h0);
    do_txn(0, 1, 32'h4, 32'hA5A5A5A5, 4'h0, 0, got, a1);
    do_txn(0, 0, 32'h8, 32'h0, 4'h0, 5, got, a1);

    // LATENCY=0: back-to-back acceptance every two cycles
    do_txn(1, 1, 32'h7C, 32'h13579BDF, 4'hF, 0, got, a1);
    do_txn(1, 0, 32'h7C, 32'h0, 4'h0, 0, got, a2);
    check("b2b_period", 32'(a2 - a1), 32'd2);
    check("l0_load", got, 32'h13579BDF);

    // LATENCY=4: reset while the store is still waiting
    while (!req_ready[2]) begin @(posedge clk); #1; end
    req_valid[2] = 1; req_write[2] = 1; req_addr[2] = 32'h10;
    req_wdata[2] = 32'h12345678; req_wstrb[2] = 4'hF;
    @(posedge clk); #1;
    req_valid[2] = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_model();
    check1("rst_wait_valid", resp_valid[2], 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check1("rst_wait_novalid", resp_valid[2], 1'b0);
    end
    do_txn(2, 0, 32'h10, 32'h0, 4'h0, 0, got, a1);
    check("rst_wait_nowrite", got, 32'h0);

    // random traffic on every instance
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 30; n++) begin
        kind = int'($urandom_range(0, 9));
        if (kind == 0)
          a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        else if (kind == 1)
          a = 32'($urandom_range(DEPTH, 1000)) << 2;
        else
          a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        wd = $urandom;
        do_txn(d, 1'($urandom), a, wd, 4'($urandom),
               int'($urandom_range(0, 3)) == 0 ? 2 : 0, got, a1);
      end
      for (int i = 0; i < DEPTH; i++)
        do_txn(d, 0, 32'(i) << 2, 32'h0, 4'h0, 0, got, a1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
